// File: rtl/apb_sram_if.sv
// APB bus bundle between an APB master and the SRAM slave.
// Clock and reset are kept as plain ports on the modules that use this bundle.
interface apb_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   Paddr;
  logic                    Pselx;
  logic                    Penable;
  logic                    Pwrite;
  logic [DATA_WIDTH-1:0]   Pwdata;
  logic [DATA_WIDTH/8-1:0] Pstrb;
  logic                    Pready;
  logic                    Pslverr;
  logic [DATA_WIDTH-1:0]   Prdata;

  modport master (
    output Paddr, Pselx, Penable, Pwrite, Pwdata, Pstrb,
    input  Pready, Pslverr, Prdata
  );

  modport slave (
    input  Paddr, Pselx, Penable, Pwrite, Pwdata, Pstrb,
    output Pready, Pslverr, Prdata
  );
endinterface

// File: rtl/apb_sram_slave.sv
// APB slave backed by a word-addressed SRAM, with byte strobes, a fixed number of
// wait states, and an error response for out-of-range or misaligned addresses.
module apb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic      Pclk,
  input  logic      Prst,
  apb_sram_if.slave bus
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  wr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [NB-1:0]         strb_p0;
  logic [DATA_WIDTH-1:0] rdata_p0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx_live;
  logic [ADDR_WIDTH-1:0] idx_p0;
  logic                  live_in_range;
  logic                  err_p0;
  logic                  pready;
  logic                  commit_wr;

  assign idx_live      = bus.Paddr >> OFF_W;
  assign idx_p0        = addr_p0 >> OFF_W;
  assign live_in_range = ({1'b0, idx_live} < DEPTH_A);
  assign err_p0        = ({1'b0, idx_p0} >= DEPTH_A) || ((addr_p0 & OFF_MASK) != '0);
  assign pready        = (state == ACCESS) && (wait_cnt == 4'd0);
  // A reset edge that coincides with completion must not let the write through.
  assign commit_wr     = pready && wr_p0 && !err_p0 && !Prst;

  // Setup stage: capture the request and prefetch the addressed word.
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_p0  <= '0;
      wr_p0    <= 1'b0;
      wdata_p0 <= '0;
      strb_p0  <= '0;
      rdata_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Pselx && !bus.Penable) begin
            addr_p0  <= bus.Paddr;
            wr_p0    <= bus.Pwrite;
            wdata_p0 <= bus.Pwdata;
            strb_p0  <= bus.Pstrb;
            wait_cnt <= 4'(WAIT_STATES);
            rdata_p0 <= live_in_range ? mem[idx_live[MEM_AW-1:0]] : '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (pready) begin
            state <= IDLE;
          end else if (!bus.Pselx) begin
            state <= IDLE;
          end else if (bus.Penable) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access stage: byte-masked commit; memory is deliberately outside reset.
  always_ff @(posedge Pclk) begin
    if (commit_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_p0[i]) begin
          mem[idx_p0[MEM_AW-1:0]][i*8 +: 8] <= wdata_p0[i*8 +: 8];
        end
      end
    end
  end

  assign bus.Pready  = pready;
  assign bus.Pslverr = pready && err_p0;
  assign bus.Prdata  = (pready && !wr_p0 && !err_p0) ? rdata_p0 : '0;
endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench: three slaves with 0, 3 and 2 wait states share one stimulus bus;
// only the selected slave sees Pselx, and its outputs are observed through a mux.
module tb_apb_sram_slave;
  logic        Pclk = 1'b0;
  logic        Prst;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [1:0]  sel;

  logic        rdy_a [3];
  logic        err_a [3];
  logic [31:0] rd_a  [3];
  logic        pready_m;
  logic        pslverr_m;
  logic [31:0] prdata_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          cy;

  always #5 Pclk = ~Pclk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    apb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
    assign bus.Paddr   = paddr;
    assign bus.Pselx   = psel && (sel == 2'(g));
    assign bus.Penable = penable;
    assign bus.Pwrite  = pwrite;
    assign bus.Pwdata  = pwdata;
    assign bus.Pstrb   = pstrb;
    assign rdy_a[g]    = bus.Pready;
    assign err_a[g]    = bus.Pslverr;
    assign rd_a[g]     = bus.Prdata;
    apb_sram_slave #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .DEPTH      (32),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .Pclk(Pclk),
      .Prst(Prst),
      .bus (bus)
    );
  end

  assign pready_m  = rdy_a[sel];
  assign pslverr_m = err_a[sel];
  assign prdata_m  = rd_a[sel];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One APB transfer; returns data/error seen while Pready=1 and the total cycle count.
  task automatic apb_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdo,
                          output logic erro, output int cyc);
    @(negedge Pclk);
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    cyc = 1;
    @(negedge Pclk);
    penable = 1'b1;
    cyc++;
    while (!pready_m && cyc < 40) begin
      @(negedge Pclk);
      cyc++;
    end
    rdo  = prdata_m;
    erro = pslverr_m;
    check_eq("xfer_ready", {31'b0, pready_m}, 32'd1);
  endtask

  task automatic bus_idle();
    @(negedge Pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 2'd0;
    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    Prst = 1'b0;
    check_eq("rst_pready",  {31'b0, pready_m},  32'd0);
    check_eq("rst_pslverr", {31'b0, pslverr_m}, 32'd0);
    check_eq("rst_prdata",  prdata_m,           32'd0);

    // Zero wait states: write then back-to-back read of the same word
    sel = 2'd0;
    apb_xfer(8'h10, 1'b1, 32'hDEADBEEF, 4'b1111, rd, er, cy);
    check_eq("w10_cycles", cy, 32'd2);
    check_eq("w10_err", {31'b0, er}, 32'd0);
    check_eq("w10_prdata_zero", rd, 32'd0);
    apb_xfer(8'h10, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r10_cycles", cy, 32'd2);
    check_eq("r10_data", rd, 32'hDEADBEEF);
    check_eq("r10_err", {31'b0, er}, 32'd0);

    // Strobe on byte 1 only replaces bits 15:8
    apb_xfer(8'h10, 1'b1, 32'h0000AA00, 4'b0010, rd, er, cy);
    apb_xfer(8'h10, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r10_strb_data", rd, 32'hDEADAAEF);

    // Error responses leave memory untouched
    apb_xfer(8'h00, 1'b1, 32'h12345678, 4'b1111, rd, er, cy);
    apb_xfer(8'h04, 1'b1, 32'hA5A5A5A5, 4'b1111, rd, er, cy);
    apb_xfer(8'h80, 1'b1, 32'hFFFFFFFF, 4'b1111, rd, er, cy);
    check_eq("w80_err", {31'b0, er}, 32'd1);
    check_eq("w80_cycles", cy, 32'd2);
    apb_xfer(8'h06, 1'b1, 32'hFFFFFFFF, 4'b1111, rd, er, cy);
    check_eq("w06_err", {31'b0, er}, 32'd1);
    apb_xfer(8'h00, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r00_data", rd, 32'h12345678);
    check_eq("r00_err", {31'b0, er}, 32'd0);
    apb_xfer(8'h04, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r04_data", rd, 32'hA5A5A5A5);
    apb_xfer(8'h80, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r80_err", {31'b0, er}, 32'd1);
    check_eq("r80_data_zero", rd, 32'd0);
    apb_xfer(8'h00, 1'b1, 32'hFFFFFFFF, 4'b0000, rd, er, cy);
    check_eq("w00_nostrb_err", {31'b0, er}, 32'd0);
    apb_xfer(8'h00, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("r00_nostrb_data", rd, 32'h12345678);
    bus_idle();

    // Three wait states: five-cycle transfers
    sel = 2'd1;
    apb_xfer(8'h04, 1'b1, 32'h0BADCAFE, 4'b1111, rd, er, cy);
    check_eq("ws3_w_cycles", cy, 32'd5);
    apb_xfer(8'h04, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("ws3_r_cycles", cy, 32'd5);
    check_eq("ws3_r_data", rd, 32'h0BADCAFE);
    bus_idle();

    // Two wait states: abort by dropping Pselx in the first access cycle
    sel = 2'd2;
    apb_xfer(8'h08, 1'b1, 32'h11223344, 4'b1111, rd, er, cy);
    check_eq("ws2_w_cycles", cy, 32'd4);
    @(negedge Pclk);
    paddr = 8'h08; pwrite = 1'b1; pwdata = 32'h55667788; pstrb = 4'b1111;
    psel = 1'b1; penable = 1'b0;
    @(negedge Pclk);
    psel = 1'b0;
    check_eq("abort_pready", {31'b0, pready_m}, 32'd0);
    @(negedge Pclk);
    psel = 1'b1; penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Pclk);
      check_eq("abort_idle_no_setup", {31'b0, pready_m}, 32'd0);
    end
    apb_xfer(8'h08, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("abort_r08_data", rd, 32'h11223344);
    bus_idle();

    // Reset on the completing edge of a write
    sel = 2'd0;
    apb_xfer(8'h14, 1'b1, 32'h01020304, 4'b1111, rd, er, cy);
    @(negedge Pclk);
    paddr = 8'h14; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'b1111;
    psel = 1'b1; penable = 1'b0;
    @(negedge Pclk);
    penable = 1'b1;
    check_eq("rstacc_pready_before", {31'b0, pready_m}, 32'd1);
    Prst = 1'b1;
    @(negedge Pclk);
    Prst = 1'b0; psel = 1'b0; penable = 1'b0;
    check_eq("rstacc_pready",  {31'b0, pready_m},  32'd0);
    check_eq("rstacc_pslverr", {31'b0, pslverr_m}, 32'd0);
    check_eq("rstacc_prdata",  prdata_m,           32'd0);
    apb_xfer(8'h14, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("rstacc_r14_data", rd, 32'h01020304);
    apb_xfer(8'h14, 1'b1, 32'hCAFEF00D, 4'b1111, rd, er, cy);
    check_eq("post_rst_w_cycles", cy, 32'd2);
    apb_xfer(8'h14, 1'b0, 32'h0, 4'b0000, rd, er, cy);
    check_eq("post_rst_r14_data", rd, 32'hCAFEF00D);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
